systolic_seq_ctrl: RTL and testbench

//  Sequencer for an N x N output-stationary systolic array built from row modules.

---
 rtl/systolic_seq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// ============================================================================
// systolic_seq_ctrl
// ----------------------------------------------------------------------------
// Sequencer for an N x N output-stationary systolic array built from row
// modules. One multiply runs as follows:
//   IDLE -> CLEAR (accumulators wiped) -> FEED (K_DIM operand reads)
//        -> DRAIN (2*N cycles for the wavefront to pass) -> DONE (results
//        captured, one-cycle done pulse) -> IDLE.
// Each FEED cycle reads column k of A and row k of B from external operand
// buffers. That read data is then skewed diagonally so row i sees A[i][k] i
// cycles late and column j sees B[k][j] j cycles late. Every lane is forced
// to zero whenever it does not carry a real operand, so the PEs never add
// spurious products.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_start       request one multiply, only honoured in IDLE
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse, o_result_out valid from this cycle
//   o_rd_en       operand buffer read strobe
//   o_rd_addr     k index (A column k, B row k)
//   i_a_rd_data   lane i = A[i][k], valid one cycle after o_rd_en
//   i_b_rd_data   lane j = B[k][j], valid one cycle after o_rd_en
//   o_left_feed   lane i -> in_left of array row i
//   o_up_feed     lane j -> in_up of array column j (top row)
//   o_pe_clear    clears every PE accumulator
//   i_result_in   array results, PE(i,j) at index i*N+j
//   o_result_out  copy of i_result_in taken on the done edge
// ============================================================================
module systolic_seq_ctrl #(
    parameter int  num_of_PE    = 16,
    parameter int  K_DIM        = 16,
    parameter int  data_width   = 8,
    parameter int  result_width = 16,
    localparam int ADDR_W       = $clog2(K_DIM)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_start,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic                                        o_rd_en,
    output logic [ADDR_W-1:0]                           o_rd_addr,
    input  logic [data_width*num_of_PE-1:0]             i_a_rd_data,
    input  logic [data_width*num_of_PE-1:0]             i_b_rd_data,
    output logic [data_width*num_of_PE-1:0]             o_left_feed,
    output logic [data_width*num_of_PE-1:0]             o_up_feed,
    output logic                                        o_pe_clear,
    input  logic [result_width*num_of_PE*num_of_PE-1:0] i_result_in,
    output logic [result_width*num_of_PE*num_of_PE-1:0] o_result_out
);

    // DRAIN lasts 2*num_of_PE cycles, so its counter needs to reach 2N-1.
    localparam int                  DRAIN_W    = $clog2(2 * num_of_PE);
    localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(K_DIM - 1);
    localparam logic [DRAIN_W-1:0]  LAST_DRAIN = DRAIN_W'(2 * num_of_PE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               r_state;
    logic [DRAIN_W-1:0]   r_drainCnt;

    // High in exactly the cycles where the operand buffers present valid
    // data, i.e. one cycle behind the read strobe.
    logic                 r_rdValid;

    // Operand lanes after zero masking, and the skewed lanes that drive
    // the array edges.
    logic [data_width-1:0] w_aMasked  [num_of_PE];
    logic [data_width-1:0] w_bMasked  [num_of_PE];
    logic [data_width-1:0] w_leftLane [num_of_PE];
    logic [data_width-1:0] w_upLane   [num_of_PE];

    // ------------------------------------------------------------------------
    // Main sequencer. Every control output is a register that is updated on
    // the same edge as the state change, so each output lines up exactly
    // with the state it belongs to. The FEED counter doubles as the read
    // address and parks at K_DIM-1 rather than wrapping. The result capture
    // happens on the edge that enters DONE, so o_result_out is already
    // valid in the cycle where o_done is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_drainCnt   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_rd_en      <= 1'b0;
            o_rd_addr    <= '0;
            o_pe_clear   <= 1'b0;
            o_result_out <= '0;
        end else begin
            o_done     <= 1'b0;
            o_pe_clear <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_CLEAR;
                        o_busy     <= 1'b1;
                        o_pe_clear <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    r_state   <= ST_FEED;
                    o_rd_en   <= 1'b1;
                    o_rd_addr <= '0;
                end

                ST_FEED: begin
                    if (o_rd_addr == LAST_ADDR) begin
                        r_state    <= ST_DRAIN;
                        o_rd_en    <= 1'b0;
                        r_drainCnt <= '0;
                    end else begin
                        o_rd_addr <= o_rd_addr + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (r_drainCnt == LAST_DRAIN) begin
                        r_state      <= ST_DONE;
                        o_done       <= 1'b1;
                        o_result_out <= i_result_in;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                    o_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read-data qualifier. The buffers answer one cycle after the strobe,
    // so a delayed copy of o_rd_en marks the cycles whose data is real.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= o_rd_en;
        end
    end

    // ------------------------------------------------------------------------
    // Zero masking. Outside valid read cycles the buffer outputs are treated
    // as garbage. Forcing them to zero here means every skew stage only ever
    // holds either a real operand or zero.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < num_of_PE; i++) begin
            w_aMasked[i] = '0;
            w_bMasked[i] = '0;
            if (r_rdValid) begin
                w_aMasked[i] = i_a_rd_data[i*data_width +: data_width];
                w_bMasked[i] = i_b_rd_data[i*data_width +: data_width];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Diagonal skew. Lane n gets a private shift register of depth n. Lane 0
    // passes straight through, which puts A[i][k] on row i in cycle T0+k+i
    // and B[k][j] on column j in cycle T0+k+j. The chains are reset so an
    // aborted run leaves nothing behind to leak into the next one.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < num_of_PE; gi++) begin : g_lane
        if (gi == 0) begin : g_direct
            assign w_leftLane[gi] = w_aMasked[gi];
            assign w_upLane[gi]   = w_bMasked[gi];
        end else begin : g_delay
            logic [data_width-1:0] r_aPipe [gi];
            logic [data_width-1:0] r_bPipe [gi];

            // Shift one stage per cycle, entering from the masked lane.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int s = 0; s < gi; s++) begin
                        r_aPipe[s] <= '0;
                        r_bPipe[s] <= '0;
                    end
                end else begin
                    r_aPipe[0] <= w_aMasked[gi];
                    r_bPipe[0] <= w_bMasked[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_aPipe[s] <= r_aPipe[s-1];
                        r_bPipe[s] <= r_bPipe[s-1];
                    end
                end
            end

            assign w_leftLane[gi] = r_aPipe[gi-1];
            assign w_upLane[gi]   = r_bPipe[gi-1];
        end
    end

    // ------------------------------------------------------------------------
    // Pack the skewed lanes onto the flat edge buses.
    // ------------------------------------------------------------------------
    always_comb begin
        o_left_feed = '0;
        o_up_feed   = '0;
        for (int i = 0; i < num_of_PE; i++) begin
            o_left_feed[i*data_width +: data_width] = w_leftLane[i];
            o_up_feed[i*data_width +: data_width]   = w_upLane[i];
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ============================================================================
// tb_systolic_seq_ctrl
// ----------------------------------------------------------------------------
// Bench for systolic_seq_ctrl with a 4x4 array and K=4. It contains:
//   - a behavioural operand buffer, which drives junk whenever it is not
//     being read,
//   - a behavioural output-stationary array of multiply-accumulate PEs,
//   - a timeline model, which works out every output from the start cycle
//     of the run and from A*B,
//   - directed scenarios with literal expectations.
// ============================================================================
module tb_systolic_seq_ctrl;

    localparam int N   = 4;
    localparam int K   = 4;
    localparam int DW  = 8;
    localparam int RW  = 16;
    localparam int AW  = 2;
    localparam int LAT = K + 2*N + 2;
    localparam int LV  = DW*N;
    localparam int RV  = RW*N*N;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [LV-1:0] aRdData;
    logic [LV-1:0] bRdData;
    logic [LV-1:0] leftFeed;
    logic [LV-1:0] upFeed;
    logic          peClear;
    logic [RV-1:0] resultIn;
    logic [RV-1:0] resultOut;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    // Buffer contents: bufA[i][k] = A[i][k], bufB[k][j] = B[k][j].
    int bufA [N][N];
    int bufB [N][N];

    systolic_seq_ctrl #(
        .num_of_PE    (N),
        .K_DIM        (K),
        .data_width   (DW),
        .result_width (RW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_rd_en      (rdEn),
        .o_rd_addr    (rdAddr),
        .i_a_rd_data  (aRdData),
        .i_b_rd_data  (bRdData),
        .o_left_feed  (leftFeed),
        .o_up_feed    (upFeed),
        .o_pe_clear   (peClear),
        .i_result_in  (resultIn),
        .o_result_out (resultOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles. A cycle is numbered by the value cyc takes at its opening edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer: answers one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rdEn === 1'b1) begin
                aRdData[i*DW +: DW] <= DW'(bufA[i][rdAddr]);
                bRdData[i*DW +: DW] <= DW'(bufB[rdAddr][i]);
            end else begin
                aRdData[i*DW +: DW] <= 8'hA5;
                bRdData[i*DW +: DW] <= 8'h5A;
            end
        end
    end

    // Behavioural array: A moves right and B moves down, one PE per cycle.
    logic [DW-1:0] aPipe [N][N];
    logic [DW-1:0] bPipe [N][N];
    logic [RW-1:0] acc   [N][N];
    logic [DW-1:0] peA;
    logic [DW-1:0] peB;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) peA = leftFeed[i*DW +: DW];
                else        peA = aPipe[i][j-1];
                if (i == 0) peB = upFeed[j*DW +: DW];
                else        peB = bPipe[i-1][j];
                aPipe[i][j] <= peA;
                bPipe[i][j] <= peB;
                acc[i][j]   <= peClear ? '0 : acc[i][j] + RW'(peA) * RW'(peB);
            end
        end
    end

    always_comb begin
        resultIn = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                resultIn[(i*N+j)*RW +: RW] = acc[i][j];
    end

    // ------------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------------
    bit            active = 1'b0;
    int            runS   = 0;
    int            mA [N][N];
    int            mB [N][N];
    logic [RV-1:0] expRes = '0;

    function automatic logic [RV-1:0] matProduct(input int a[N][N], input int b[N][N]);
        logic [RV-1:0] v;
        int            s;
        v = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < K; k++) s += a[i][k] * b[k][j];
                v[(i*N+j)*RW +: RW] = RW'(s);
            end
        end
        return v;
    endfunction

    // A run that starts in cycle S keeps the block busy through cycle S+LAT.
    function automatic bit modelIdle(input int c);
        return !active || (c > runS + LAT);
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            active = 1'b0;
            expRes = '0;
        end else begin
            if (active && cyc == runS + LAT - 1) expRes = matProduct(mA, mB);
            if (start === 1'b1 && modelIdle(cyc)) begin
                active = 1'b1;
                runS   = cyc;
                mA     = bufA;
                mB     = bufB;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [RV-1:0] act, input logic [RV-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle compare against the timeline model
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        int            r;
        int            k;
        logic          expBusy;
        logic          expClear;
        logic          expRdEn;
        logic          expDone;
        logic [LV-1:0] expLeft;
        logic [LV-1:0] expUp;
        if (cyc >= 1) begin
            r        = active ? (cyc - runS) : -100;
            expBusy  = (r >= 1 && r <= LAT);
            expClear = (r == 1);
            expRdEn  = (r >= 2 && r <= K + 1);
            expDone  = (r == LAT);
            expLeft  = '0;
            expUp    = '0;
            for (int i = 0; i < N; i++) begin
                k = r - 3 - i;
                if (k >= 0 && k < K) begin
                    expLeft[i*DW +: DW] = DW'(mA[i][k]);
                    expUp[i*DW +: DW]   = DW'(mB[k][i]);
                end
            end
            checkOutput("busy",       RV'(busy),     RV'(expBusy));
            checkOutput("pe_clear",   RV'(peClear),  RV'(expClear));
            checkOutput("rd_en",      RV'(rdEn),     RV'(expRdEn));
            checkOutput("done",       RV'(done),     RV'(expDone));
            checkOutput("left_feed",  RV'(leftFeed), RV'(expLeft));
            checkOutput("up_feed",    RV'(upFeed),   RV'(expUp));
            checkOutput("result_out", resultOut,     expRes);
            if (expRdEn) checkOutput("rd_addr", RV'(rdAddr), RV'(r - 2));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic waitCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic loadOperands(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                case (mode)
                    0: begin bufA[i][k] = (i == k) ? 1 : 0; bufB[i][k] = 4*i + k + 1; end
                    1: begin bufA[i][k] = 16*i + k + 1;     bufB[i][k] = i + k + 1;   end
                    2: begin bufA[i][k] = (i == k) ? 1 : 0; bufB[i][k] = 2*i + k + 3; end
                    3: begin bufA[i][k] = i + k + 1;        bufB[i][k] = (i*k) % 5 + 1; end
                    default: begin bufA[i][k] = (i == k) ? 2 : 0; bufB[i][k] = i + k + 1; end
                endcase
            end
        end
    endtask

    // Pulse start for one cycle and return the cycle in which it was sampled.
    task automatic applyStimulus(output int s);
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int            s;
        int            s2;
        int            doneCount;
        logic [RV-1:0] lit;

        rst   = 1'b1;
        start = 1'b0;
        loadOperands(0);
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset busy",       RV'(busy),     RV'(1'b0));
        checkOutput("reset done",       RV'(done),     RV'(1'b0));
        checkOutput("reset rd_en",      RV'(rdEn),     RV'(1'b0));
        checkOutput("reset pe_clear",   RV'(peClear),  RV'(1'b0));
        checkOutput("reset left_feed",  RV'(leftFeed), RV'(0));
        checkOutput("reset result_out", resultOut,     RV'(0));
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: identity A, so the result must equal B.
        $display("[TB] scenario 1: identity A");
        loadOperands(0);
        applyStimulus(s);
        checkOutput("t1 pe_clear at S+1", RV'(peClear), RV'(1'b1));
        for (int k = 0; k < K; k++) begin
            waitCycle(s + 2 + k);
            checkOutput("t1 rd_addr", RV'(rdAddr), RV'(k));
        end
        waitCycle(s + 13);
        checkOutput("t1 done low at S+13", RV'(done), RV'(1'b0));
        waitCycle(s + 14);
        checkOutput("t1 done at S+14", RV'(done), RV'(1'b1));
        lit = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                lit[(i*N+j)*RW +: RW] = RW'(4*i + j + 1);
        checkOutput("t1 result_out == B", resultOut, lit);
        checkOutput("t1 C00 literal", RV'(resultOut[15:0]),    RV'(16'h0001));
        checkOutput("t1 C33 literal", RV'(resultOut[255:240]), RV'(16'h0010));
        waitCycle(s + 16);

        // Scenario 2: skew timing on specific lanes.
        $display("[TB] scenario 2: skew");
        loadOperands(1);
        applyStimulus(s);
        for (int c = s + 1; c <= s + 9; c++) begin
            waitCycle(c);
            if (c <= s + 5) checkOutput("t2 up lane3 zero before T0+3", RV'(upFeed[31:24]), RV'(8'h00));
            if (c == s + 6) checkOutput("t2 up lane3 at T0+3",  RV'(upFeed[31:24]),   RV'(8'h04));
            if (c == s + 4) checkOutput("t2 left lane2 at T0+1", RV'(leftFeed[23:16]), RV'(8'h00));
            if (c == s + 5) checkOutput("t2 left lane2 at T0+2", RV'(leftFeed[23:16]), RV'(8'h21));
            if (c == s + 8) checkOutput("t2 left lane2 at T0+5", RV'(leftFeed[23:16]), RV'(8'h24));
            if (c == s + 9) checkOutput("t2 left lane2 at T0+6", RV'(leftFeed[23:16]), RV'(8'h00));
        end
        waitCycle(s + 16);

        // Scenario 3: start held high through a whole run.
        $display("[TB] scenario 3: start held high");
        loadOperands(2);
        start     = 1'b1;
        s         = cyc;
        doneCount = 0;
        for (int c = s; c <= s + 14; c++) begin
            waitCycle(c);
            if (done === 1'b1) doneCount++;
        end
        waitCycle(s + 15);
        checkOutput("t3 idle at S+15", RV'(busy), RV'(1'b0));
        waitCycle(s + 16);
        checkOutput("t3 pe_clear on restart", RV'(peClear), RV'(1'b1));
        start = 1'b0;
        checkOutput("t3 single done", RV'(doneCount), RV'(1));
        waitCycle(s + 31);

        // Scenario 4: reset in the 2nd FEED cycle, then a fresh run.
        $display("[TB] scenario 4: reset mid-feed");
        loadOperands(3);
        applyStimulus(s);
        waitCycle(s + 3);
        rst = 1'b1;
        waitCycle(s + 4);
        checkOutput("t4 busy after rst",       RV'(busy),     RV'(1'b0));
        checkOutput("t4 left_feed after rst",  RV'(leftFeed), RV'(0));
        checkOutput("t4 up_feed after rst",    RV'(upFeed),   RV'(0));
        checkOutput("t4 result_out after rst", resultOut,     RV'(0));
        rst = 1'b0;
        waitCycle(s + 6);
        applyStimulus(s2);
        waitCycle(s2 + 14);
        checkOutput("t4 done at S'+14", RV'(done), RV'(1'b1));
        checkOutput("t4 result after restart", resultOut, matProduct(bufA, bufB));
        waitCycle(s2 + 16);

        // Scenario 5: back-to-back runs with different operands.
        $display("[TB] scenario 5: back-to-back");
        loadOperands(0);
        applyStimulus(s);
        waitCycle(s + 15);
        loadOperands(4);
        applyStimulus(s2);
        waitCycle(s2 + 13);
        lit = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                lit[(i*N+j)*RW +: RW] = RW'(4*i + j + 1);
        checkOutput("t5 first result holds", resultOut, lit);
        waitCycle(s2 + 14);
        lit = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                lit[(i*N+j)*RW +: RW] = RW'(2*(i + j + 1));
        checkOutput("t5 second done", RV'(done), RV'(1'b1));
        checkOutput("t5 second result", resultOut, lit);
        checkOutput("t5 C00 literal", RV'(resultOut[15:0]), RV'(16'h0002));
        waitCycle(s2 + 18);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
